z_core_mdu_ctrl: RTL and testbench
==================================

// Module: z_core_mdu_ctrl
// PURPOSE
//  Sequencer for RISC-V M-extension ops in Z-Core. Takes one request at a time over a valid/ready handshake.
//  Drives the shared z_core_mult_unit and holds its operands stable while it waits.
//  Runs an internal restoring divider at 1 bit/cycle and returns a tagged result over a valid/ready handshake.
//  Sits beside the ALU; the core stalls while busy is high.
// PARAMETERS
//  MUL_CYCLES  1  cycles mult_unit operands are held before the result is captured (legal 1..8)
//  TAG_W       5  width of the destination-register tag carried through (rd)
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset
//  flush          in   1      abort current op, drop pending response
//  req_valid      in   1      request present
//  req_ready      out  1      request accepted when valid&ready
//  req_op         in   3      funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_rs1        in   32     operand 1 / dividend
//  req_rs2        in   32     operand 2 / divisor
//  req_rd         in   TAG_W  destination tag
//  mul_op1        out  32     to mult_unit op1
//  mul_op2        out  32     to mult_unit op2
//  mul_op1_signed out  1      to mult_unit: 1 for MULH, MULHSU
//  mul_op2_signed out  1      to mult_unit: 1 for MULH only
//  mul_result     in   64     from mult_unit
//  resp_valid     out  1      result present
//  resp_ready     in   1      consumer accepts
//  resp_data      out  32     result
//  resp_rd        out  TAG_W  tag of result
//  resp_illegal   out  1      op not supported in this build
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  - clk is the single clock; rst is synchronous and active-high. Priority: rst > flush > normal.
//  - Reset: state IDLE; resp_valid, resp_illegal, busy = 0; resp_data, resp_rd, mul_op1/2, signed flags = 0.
//  - States: IDLE, MUL, DIV, FIX, DONE. req_ready = (state==IDLE) && !flush.
//  - Accept in IDLE: latch op, rs1, rs2, rd. op[2]=0 -> MUL, else DIV.
//  - MUL: mul_op1/2 and signed flags registered from the latched values; they stay constant until the next accept.
//    A counter runs MUL_CYCLES cycles. On the last cycle, capture mul_result[31:0] (MUL) or [63:32] (others), then go to DONE.
//    resp_valid rises MUL_CYCLES cycles after the accept edge.
//  - DIV, first cycle, special cases go straight to DONE (latency 1):
//    divisor==0: quotient = 0xFFFFFFFF, remainder = dividend.
//    signed op with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//  - DIV, otherwise: signed ops use operand magnitudes. 32 restoring iterations, 1 quotient bit per cycle, MSB first,
//    33-bit partial remainder. Then FIX: negate quotient if operand signs differ; negate remainder if dividend < 0.
//    Then DONE. resp_valid rises 33 cycles after the accept edge.
//  - DONE: resp_valid = 1; resp_data, resp_rd, resp_illegal held stable until resp_ready, then IDLE.
//    Minimum one idle cycle between a response handshake and the next accept.
//  - flush in any state: next state IDLE, resp_valid = 0, counters cleared. A request in the same cycle is not accepted.
//    Mid-op rst behaves the same and also applies all reset values.
//  - All arithmetic is 32-bit modulo; unsigned ops ignore sign bits.
//  - mult_unit is combinational; MUL_CYCLES exists for a registered or retimed replacement.
// CONFIGURATION
//  Macro Z_CORE_MDU_DIV_EN.
//  - Defined: divider, DIV and FIX states present; resp_illegal is always 0.
//  - Undefined: no divider logic. Ops 4..7 are accepted and reach DONE after 1 cycle with resp_data = 0 and
//    resp_illegal = 1. Mult ops are unchanged.
// TESTING
//  1. MUL 0x00000007 x 0xFFFFFFFD -> resp_data 0xFFFFFFEB, resp_valid MUL_CYCLES cycles after accept, resp_rd echoed.
//  2. 0xFFFFFFFF x 0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//     Check signed flags (1,1), (1,0), (0,0).
//  3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; resp_valid at accept+33.
//  4. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; all at accept+1.
//  5. Hold resp_ready low 5 cycles in DONE -> resp_valid/data/rd stable, req_ready 0, busy 1.
//     Raise resp_ready -> IDLE next cycle.
//  6. Flush at divide iteration 10 -> busy 0 next cycle, no resp_valid.
//     rst at iteration 10 -> all outputs at reset values. A following MUL completes correctly.

Source files
------------

// File: rtl/z_core_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : z_core_mdu_ctrl
// Purpose  : Sequencer for the RISC-V M-extension in Z-Core. It accepts one
//            request at a time, drives the shared z_core_mult_unit with
//            operands held stable, runs a 1-bit/cycle restoring divider and
//            returns a tagged result. The core stalls while busy is high.
// Build    : macro Z_CORE_MDU_DIV_EN enables the divider. Without it, ops
//            4..7 complete after one cycle with resp_data = 0 and
//            resp_illegal = 1.
// Params   : MUL_CYCLES - cycles mult_unit operands are held (1..8)
//            TAG_W      - destination tag width
// Ports    : clk, rst (sync, active-high), flush
//            req_valid/req_ready, req_op, req_rs1, req_rs2, req_rd
//            mul_op1, mul_op2, mul_op1_signed, mul_op2_signed, mul_result
//            resp_valid/resp_ready, resp_data, resp_rd, resp_illegal, busy
// Revision : 1.0 - initial release
// ============================================================================
module z_core_mdu_ctrl #(
  parameter int MUL_CYCLES = 1,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_rd,
  output logic [31:0]      mul_op1,
  output logic [31:0]      mul_op2,
  output logic             mul_op1_signed,
  output logic             mul_op2_signed,
  input  logic [63:0]      mul_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_rd,
  output logic             resp_illegal,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_rd;
  logic [4:0]       r_cnt;
  logic             w_accept;
  logic             w_load;
  logic [31:0]      w_load_data;
  logic             w_load_ill;

  assign req_ready  = (r_state == S_IDLE) && !flush;
  assign w_accept   = req_valid && req_ready;
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_DONE);

`ifdef Z_CORE_MDU_DIV_EN
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_quo;   // dividend magnitude shifts out MSB first, quotient shifts in
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;  // divisor magnitude
  logic [32:0] w_shift; // 33-bit partial remainder for this iteration
  logic [32:0] w_diff;
  logic        w_req_sgn;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_quo_neg;
  logic        w_rem_neg;

  assign w_req_sgn  = !req_op[0];
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign w_div_zero = (r_rs2 == 32'd0);
  assign w_div_ovf  = !r_op[0] && (r_rs1 == 32'h8000_0000) && (r_rs2 == 32'hFFFF_FFFF);
  assign w_quo_neg  = !r_op[0] && (r_rs1[31] ^ r_rs2[31]);
  assign w_rem_neg  = !r_op[0] && r_rs1[31];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and response load
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_load_data = 32'd0;
    w_load_ill  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = req_op[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == MUL_LAST) begin
          w_next      = S_DONE;
          w_load      = 1'b1;
          w_load_data = (r_op == 3'd0) ? mul_result[31:0] : mul_result[63:32];
        end
      end
      S_DIV: begin
`ifdef Z_CORE_MDU_DIV_EN
        // Special cases resolve on the first divide cycle
        if ((r_cnt == 5'd0) && w_div_zero) begin
          w_next      = S_DONE;
          w_load      = 1'b1;
          w_load_data = r_op[1] ? r_rs1 : 32'hFFFF_FFFF;
        end else if ((r_cnt == 5'd0) && w_div_ovf) begin
          w_next      = S_DONE;
          w_load      = 1'b1;
          w_load_data = r_op[1] ? 32'd0 : 32'h8000_0000;
        end else if (r_cnt == 5'd31) begin
          w_next = S_FIX;
        end
`else
        w_next     = S_DONE;
        w_load     = 1'b1;
        w_load_ill = 1'b1;
`endif
      end
`ifdef Z_CORE_MDU_DIV_EN
      S_FIX: begin
        w_next = S_DONE;
        w_load = 1'b1;
        if (r_op[1]) begin
          w_load_data = w_rem_neg ? (32'd0 - r_rem) : r_rem;
        end else begin
          w_load_data = w_quo_neg ? (32'd0 - r_quo) : r_quo;
        end
      end
`endif
      S_DONE: begin
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (flush) begin
      w_next = S_IDLE;
      w_load = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op           <= 3'd0;
      r_rd           <= '0;
      r_cnt          <= 5'd0;
      mul_op1        <= 32'd0;
      mul_op2        <= 32'd0;
      mul_op1_signed <= 1'b0;
      mul_op2_signed <= 1'b0;
      resp_data      <= 32'd0;
      resp_rd        <= '0;
      resp_illegal   <= 1'b0;
`ifdef Z_CORE_MDU_DIV_EN
      r_rs1          <= 32'd0;
      r_rs2          <= 32'd0;
      r_quo          <= 32'd0;
      r_rem          <= 32'd0;
      r_dvsr         <= 32'd0;
`endif
    end else if (flush) begin
      r_cnt <= 5'd0;
    end else begin
      if (w_accept) begin
        r_op           <= req_op;
        r_rd           <= req_rd;
        r_cnt          <= 5'd0;
        mul_op1        <= req_rs1;
        mul_op2        <= req_rs2;
        mul_op1_signed <= (req_op == 3'd1) || (req_op == 3'd2);
        mul_op2_signed <= (req_op == 3'd1);
`ifdef Z_CORE_MDU_DIV_EN
        r_rs1          <= req_rs1;
        r_rs2          <= req_rs2;
        r_rem          <= 32'd0;
        r_quo          <= (w_req_sgn && req_rs1[31]) ? (32'd0 - req_rs1) : req_rs1;
        r_dvsr         <= (w_req_sgn && req_rs2[31]) ? (32'd0 - req_rs2) : req_rs2;
`endif
      end else if (r_state == S_MUL) begin
        r_cnt <= r_cnt + 5'd1;
`ifdef Z_CORE_MDU_DIV_EN
      end else if (r_state == S_DIV) begin
        // Restoring step: keep the subtraction only if it did not borrow
        r_cnt <= r_cnt + 5'd1;
        if (!w_diff[32]) begin
          r_rem <= w_diff[31:0];
          r_quo <= {r_quo[30:0], 1'b1};
        end else begin
          r_rem <= w_shift[31:0];
          r_quo <= {r_quo[30:0], 1'b0};
        end
`endif
      end
      if (w_load) begin
        resp_data    <= w_load_data;
        resp_rd      <= r_rd;
        resp_illegal <= w_load_ill;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z_core_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_z_core_mdu_ctrl
// Purpose  : Testbench for z_core_mdu_ctrl. A transaction-level reference
//            model predicts every output each cycle; directed cases pin the
//            documented results, then randomized traffic with flush/reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z_core_mdu_ctrl;

  localparam int MUL_C = 3;
  localparam int TAG_W = 5;
`ifdef Z_CORE_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_rd;
  logic [31:0]      mul_op1;
  logic [31:0]      mul_op2;
  logic             mul_op1_signed;
  logic             mul_op2_signed;
  logic [63:0]      mul_result;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_rd;
  logic             resp_illegal;
  logic             busy;

  z_core_mdu_ctrl #(.MUL_CYCLES(MUL_C), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_op1_signed(mul_op1_signed), .mul_op2_signed(mul_op2_signed),
    .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_illegal(resp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational multiplier standing in for z_core_mult_unit
  function automatic logic [63:0] mult_unit(input logic [31:0] a, input logic [31:0] b,
                                            input logic s1, input logic s2);
    logic [63:0] x;
    logic [63:0] y;
    x = s1 ? {{32{a[31]}}, a} : {32'd0, a};
    y = s2 ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  assign mul_result = mult_unit(mul_op1, mul_op2, mul_op1_signed, mul_op2_signed);

  // Reference result of one operation
  typedef struct packed {
    logic [31:0] d;
    logic        ill;
    logic [5:0]  lat;
  } res_t;

  function automatic res_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      sa;
    longint      sb;
    longint      p;
    int          ia;
    int          ib;
    logic [31:0] q;
    logic [31:0] rm;
    logic [63:0] pv;
    r.d   = 32'd0;
    r.ill = 1'b0;
    r.lat = 6'(MUL_C);
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    if (!op[2]) begin
      case (op[1:0])
        2'd0: p = sa * sb;
        2'd1: p = sa * sb;
        2'd2: p = sa * longint'({32'd0, b});
        default: p = longint'({32'd0, a}) * longint'({32'd0, b});
      endcase
      pv  = p;
      r.d = (op == 3'd0) ? pv[31:0] : pv[63:32];
    end else if (!DIV_EN) begin
      r.ill = 1'b1;
      r.lat = 6'd1;
    end else begin
      r.lat = 6'd33;
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF; rm = a; r.lat = 6'd1;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; rm = 32'd0; r.lat = 6'd1;
      end else if (!op[0]) begin
        q = ia / ib; rm = ia % ib;
      end else begin
        q = a / b; rm = a % b;
      end
      r.d = op[1] ? rm : q;
    end
    return r;
  endfunction

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-level transaction model
  logic             m_busy = 1'b0;
  logic             m_valid = 1'b0;
  int               m_cnt = 0;
  res_t             m_pend = '0;
  logic [TAG_W-1:0] m_pend_rd = '0;
  logic [31:0]      m_data = '0;
  logic [TAG_W-1:0] m_rd = '0;
  logic             m_ill = 1'b0;
  logic [31:0]      m_mop1 = '0;
  logic [31:0]      m_mop2 = '0;
  logic             m_s1 = 1'b0;
  logic             m_s2 = 1'b0;
  logic             m_rst_state = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
      m_data <= '0; m_rd <= '0; m_ill <= 1'b0;
      m_mop1 <= '0; m_mop2 <= '0; m_s1 <= 1'b0; m_s2 <= 1'b0;
      m_rst_state <= 1'b1;
    end else if (flush) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_pend      <= ref_op(req_op, req_rs1, req_rs2);
        m_cnt       <= int'(ref_op(req_op, req_rs1, req_rs2).lat);
        m_pend_rd   <= req_rd;
        m_busy      <= 1'b1;
        m_rst_state <= 1'b0;
        m_mop1      <= req_rs1;
        m_mop2      <= req_rs2;
        m_s1        <= (req_op == 3'd1) || (req_op == 3'd2);
        m_s2        <= (req_op == 3'd1);
      end
    end else if (m_valid) begin
      if (resp_ready) begin
        m_busy <= 1'b0; m_valid <= 1'b0;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_data  <= m_pend.d;
        m_rd    <= m_pend_rd;
        m_ill   <= m_pend.ill;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, !m_busy && !flush);
      chk("busy", busy, m_busy);
      chk("resp_valid", resp_valid, m_valid);
      chk("mul_op1", mul_op1, m_mop1);
      chk("mul_op2", mul_op2, m_mop2);
      chk("mul_op1_signed", mul_op1_signed, m_s1);
      chk("mul_op2_signed", mul_op2_signed, m_s2);
      if (m_valid || m_rst_state) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_rd", resp_rd, m_rd);
        chk("resp_illegal", resp_illegal, m_ill);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] rd, input int hold,
                        input logic [31:0] exp_d, input int exp_lat, input string nm);
    int lat;
    int guard;
    guard = 0;
    while (m_busy && guard < 100) begin tick(); guard++; end
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin tick(); lat++; end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " data"}, resp_data, exp_d);
    chk({nm, " rd"}, resp_rd, rd);
    chk({nm, " illegal"}, resp_illegal, op[2] && !DIV_EN);
    if (hold > 0) begin
      repeat (hold) tick();
      chk({nm, " held valid"}, resp_valid, 1'b1);
      chk({nm, " held data"}, resp_data, exp_d);
      chk({nm, " held req_ready"}, req_ready, 1'b0);
      chk({nm, " held busy"}, busy, 1'b1);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({nm, " idle after handshake"}, busy, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7, 0))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(15, 0));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    res_t pr;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; resp_ready = 1'b0;

    // Pin the reference model with hand-computed values
    pr = ref_op(3'd0, 32'h7, 32'hFFFF_FFFD);        chk("pin MUL", pr.d, 32'hFFFF_FFEB);
    pr = ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk("pin MULHU", pr.d, 32'hFFFF_FFFE);
    pr = ref_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk("pin MULH", pr.d, 32'h0);
    pr = ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk("pin MULHSU", pr.d, 32'hFFFF_FFFF);
    pr = ref_op(3'd4, 32'hFFFF_FFF9, 32'd2);         chk("pin DIV", pr.d, DIV_EN ? 32'hFFFF_FFFD : 32'h0);
    pr = ref_op(3'd6, 32'hFFFF_FFF9, 32'd2);         chk("pin REM", pr.d, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
    pr = ref_op(3'd5, 32'd100, 32'd7);               chk("pin DIVU", pr.d, DIV_EN ? 32'd14 : 32'h0);

    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset busy", busy, 1'b0);
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset resp_data", resp_data, 32'h0);

    // Multiply ops
    run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd9, 0, 32'hFFFF_FFEB, MUL_C, "MUL");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0, 32'hFFFF_FFFE, MUL_C, "MULHU");
    chk("MULHU flags", {mul_op1_signed, mul_op2_signed}, 2'b00);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0, 32'h0, MUL_C, "MULH");
    chk("MULH flags", {mul_op1_signed, mul_op2_signed}, 2'b11);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 32'hFFFF_FFFF, MUL_C, "MULHSU");
    chk("MULHSU flags", {mul_op1_signed, mul_op2_signed}, 2'b10);

    // Divide ops
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 33 : 1, "DIV");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 33 : 1, "REM");
    run_op(3'd5, 32'd100, 32'd7, 5'd6, 0, DIV_EN ? 32'd14 : 32'h0, DIV_EN ? 33 : 1, "DIVU");
    run_op(3'd7, 32'd100, 32'd7, 5'd7, 0, DIV_EN ? 32'd2 : 32'h0, DIV_EN ? 33 : 1, "REMU");
    run_op(3'd5, 32'd5, 32'd0, 5'd8, 0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1, "DIVU by 0");
    run_op(3'd7, 32'd5, 32'd0, 5'd10, 0, DIV_EN ? 32'd5 : 32'h0, 1, "REMU by 0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, DIV_EN ? 32'h8000_0000 : 32'h0, 1, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, 32'h0, 1, "REM ovf");

    // Back-pressure in DONE
    run_op(3'd0, 32'd3, 32'd4, 5'd13, 5, 32'd12, MUL_C, "MUL hold");

    // Flush at divide iteration 10, with a competing request
    tick();
    req_valid = 1'b1; req_op = 3'd5; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_rd = 5'd14;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1; req_valid = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush busy", busy, 1'b0);
    chk("flush resp_valid", resp_valid, 1'b0);
    tick();
    chk("flush no accept", busy, 1'b0);

    // Reset at divide iteration 10
    req_valid = 1'b1; req_op = 3'd4; req_rs1 = 32'd1000; req_rs2 = 32'd7; req_rd = 5'd15;
    tick();
    req_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", busy, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_data", resp_data, 32'h0);
    chk("rst resp_rd", resp_rd, 5'd0);
    chk("rst resp_illegal", resp_illegal, 1'b0);
    chk("rst mul_op1", mul_op1, 32'h0);
    chk("rst mul_op2", mul_op2, 32'h0);
    run_op(3'd0, 32'h0001_2345, 32'h10, 5'd16, 0, 32'h0012_3450, MUL_C, "MUL after rst");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid  = ($urandom_range(3, 0) != 0);
      req_op     = 3'($urandom_range(7, 0));
      req_rs1    = pick();
      req_rs2    = pick();
      req_rd     = TAG_W'($urandom);
      resp_ready = ($urandom_range(2, 0) == 0);
      flush      = ($urandom_range(59, 0) == 0);
      rst        = ($urandom_range(499, 0) == 0);
      tick();
    end
    req_valid = 1'b0; flush = 1'b0; rst = 1'b0; resp_ready = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
